// File: rtl/bitwise_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_chk_pkg
//  Purpose  : Shared types and constants for the bitwise response checker.
//             - op_e    : operation applied to the operands of each vector
//             - state_e : checker run-control states
//             - CNT_W   : width of the vector / error counters
//  Revision : 1.0 - initial release
// ============================================================================
package bitwise_chk_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : bitwise_chk_pkg
`default_nettype wire

// File: rtl/bitwise_ref_model.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_ref_model
//  Purpose  : Combinational golden model of the bitwise block under check.
//             Produces the value the block should have returned for a, b, op.
//  Ports    : a, b     (in,  N bits) operands
//             op       (in,  op_e)   operation select
//             expected (out, N bits) op applied bitwise to a and b
//  Revision : 1.0 - initial release
// ============================================================================
module bitwise_ref_model
    import bitwise_chk_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  op_e          op,
    output logic [N-1:0] expected
);

    always_comb begin
        expected = '0;
        case (op)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_XOR:  expected = a ^ b;
            OP_NOR:  expected = ~(a | b);
            default: expected = '0;
        endcase
    end

endmodule : bitwise_ref_model
`default_nettype wire

// File: rtl/bitwise_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_resp_checker
//  Purpose  : Checks a stream of responses from a bitwise AND/OR/XOR/NOR block
//             against a reference model. A run is started by a one-cycle
//             start pulse carrying the number of vectors; the checker counts
//             mismatches, records the first one, and reports pass/fail.
//  Ports    : clk, rst          clock, asynchronous active-high reset
//             start, num_vec    begin a run of num_vec vectors
//             valid, op, a, b,  one vector (operands, operation and the
//             result            response of the block under check)
//             ready             vector accepted when valid & ready
//             busy, done        run in progress / run finished
//             pass              finished run had zero mismatches
//             err_count         saturating mismatch count
//             first_err_idx/exp index and expected value of first mismatch
//             signature         MISR over accepted results (RESP_MISR_EN only)
//  Config   : define RESP_MISR_EN to add the response-signature MISR.
//  Revision : 1.0 - initial release
// ============================================================================
module bitwise_resp_checker
    import bitwise_chk_pkg::*;
#(
    parameter int           N    = 6,
    parameter logic [N-1:0] POLY = 6'b000011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [1:0]        op,
    input  logic              valid,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic [N-1:0]      result,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [N-1:0]      first_err_exp
`ifdef RESP_MISR_EN
    ,
    output logic [N-1:0]      signature
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_e             r_state;
    logic [CNT_W-1:0]   r_num_vec;
    logic [CNT_W-1:0]   r_vec_cnt;
    logic [CNT_W-1:0]   r_err_count;
    logic [CNT_W-1:0]   r_first_err_idx;
    logic [N-1:0]       r_first_err_exp;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic [N-1:0]       w_expected;
    logic               w_accept;
    logic               w_mismatch;
    logic               w_last;
    logic               w_start_ok;
    logic [CNT_W-1:0]   w_vec_cnt_inc;
    logic [CNT_W-1:0]   w_err_next;

    bitwise_ref_model #(
        .N (N)
    ) u_ref_model (
        .a        (a),
        .b        (b),
        .op       (op_e'(op)),
        .expected (w_expected)
    );

    // ready is only ever set while in RUN, so it doubles as the run gate.
    assign w_accept      = valid & r_ready;
    assign w_mismatch    = w_accept & (result != w_expected);
    assign w_vec_cnt_inc = r_vec_cnt + 1'b1;
    // num_vec is never zero in RUN, so this compare cannot wrap falsely.
    assign w_last        = (w_vec_cnt_inc == r_num_vec);
    // start is honoured only outside a run.
    assign w_start_ok    = start & (r_state != RUN);

    always_comb begin
        w_err_next = r_err_count;
        if (w_mismatch && (r_err_count != C_CNT_MAX)) begin
            w_err_next = r_err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_num_vec       <= '0;
            r_vec_cnt       <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_first_err_exp <= '0;
            r_ready         <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_num_vec       <= num_vec;
                        r_vec_cnt       <= '0;
                        r_err_count     <= '0;
                        r_first_err_idx <= '0;
                        r_first_err_exp <= '0;
                        if (num_vec != '0) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end else begin
                            // Empty run: finished immediately with no errors.
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (w_accept) begin
                        r_vec_cnt   <= w_vec_cnt_inc;
                        r_err_count <= w_err_next;
                        // A zero count means no mismatch has been seen yet;
                        // the count saturates, so it never returns to zero.
                        if (w_mismatch && (r_err_count == '0)) begin
                            r_first_err_idx <= r_vec_cnt;
                            r_first_err_exp <= w_expected;
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign ready         = r_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;
    assign first_err_exp = r_first_err_exp;

`ifdef RESP_MISR_EN
    logic [N-1:0] r_signature;
    logic [N-1:0] w_sig_next;

    // Galois-style shift with POLY feedback, folding in each accepted result.
    assign w_sig_next = {r_signature[N-2:0], 1'b0}
                      ^ (r_signature[N-1] ? POLY : '0)
                      ^ result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_signature <= '1;
        end else if (w_start_ok) begin
            r_signature <= '1;
        end else if (w_accept) begin
            r_signature <= w_sig_next;
        end
    end

    assign signature = r_signature;
`endif

endmodule : bitwise_resp_checker
`default_nettype wire

// File: tb/tb_bitwise_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitwise_resp_checker
//  Purpose  : Self-checking bench for bitwise_resp_checker (N=6). Directed
//             scenarios followed by randomized runs scored against a
//             behavioural model of the checker's rules.
//  Config   : follows RESP_MISR_EN to connect and check the signature port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_resp_checker;

    localparam int           N    = 6;
    localparam logic [N-1:0] POLY = 6'b000011;

    logic         clk;
    logic         rst;
    logic         start;
    logic [7:0]   num_vec;
    logic [1:0]   op;
    logic         valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] result;
    logic         ready;
    logic         busy;
    logic         done;
    logic         pass;
    logic [7:0]   err_count;
    logic [7:0]   first_err_idx;
    logic [N-1:0] first_err_exp;
`ifdef RESP_MISR_EN
    logic [N-1:0] signature;
`endif

    int n_cmp;
    int n_fail;

    bitwise_resp_checker #(
        .N    (N),
        .POLY (POLY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_vec       (num_vec),
        .op            (op),
        .valid         (valid),
        .a             (a),
        .b             (b),
        .result        (result),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp)
`ifdef RESP_MISR_EN
        ,
        .signature     (signature)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural reference ----------------
    function automatic logic [N-1:0] model_op(input logic [N-1:0] x,
                                              input logic [N-1:0] y,
                                              input logic [1:0]   o);
        logic [N-1:0] r;
        case (o)
            2'd0:    r = x & y;
            2'd1:    r = x | y;
            2'd2:    r = x ^ y;
            default: r = ~(x | y);
        endcase
        return r;
    endfunction

    function automatic logic [N-1:0] model_misr(input logic [N-1:0] s,
                                                input logic [N-1:0] r);
        logic [N:0] wide;
        wide = {s, 1'b0};
        if (s[N-1]) wide = wide ^ {1'b0, POLY};
        return wide[N-1:0] ^ r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start   = 1'b1;
        num_vec = n;
        tick();
        start   = 1'b0;
        num_vec = 8'($urandom);
    endtask

    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [1:0] ov, input logic [N-1:0] rv);
        valid  = 1'b1;
        a      = av;
        b      = bv;
        op     = ov;
        result = rv;
        tick();
        valid  = 1'b0;
        a      = N'($urandom);
        b      = N'($urandom);
        op     = 2'($urandom);
        result = N'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_done"},  32'(done),  0);
        check({tag, "_pass"},  32'(pass),  0);
        check({tag, "_err"},   32'(err_count), 0);
        check({tag, "_fidx"},  32'(first_err_idx), 0);
        check({tag, "_fexp"},  32'(first_err_exp), 0);
    endtask

    // Randomized run: gaps, garbage on idle cycles, ~25% injected errors.
    task automatic random_run(input int n);
        logic [N-1:0] av, bv, ev, rv, sig;
        logic [1:0]   ov;
        int           errs;
        int           fidx;
        logic [N-1:0] fexp;
        errs = 0;
        fidx = 0;
        fexp = '0;
        sig  = '1;
        do_start(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            av = N'($urandom);
            bv = N'($urandom);
            ov = 2'($urandom);
            ev = model_op(av, bv, ov);
            rv = ($urandom_range(0, 3) == 0) ? (ev ^ N'($urandom_range(1, 63))) : ev;
            if (rv != ev) begin
                if (errs == 0) begin
                    fidx = i;
                    fexp = ev;
                end
                errs++;
            end
            sig = model_misr(sig, rv);
            send(av, bv, ov, rv);
        end
        check("rnd_done",  32'(done), 1);
        check("rnd_busy",  32'(busy), 0);
        check("rnd_pass",  32'(pass), (errs == 0) ? 1 : 0);
        check("rnd_err",   32'(err_count), 32'(errs));
        check("rnd_fidx",  32'(first_err_idx), 32'(fidx));
        check("rnd_fexp",  32'(first_err_exp), 32'(fexp));
`ifdef RESP_MISR_EN
        check("rnd_sig",   32'(signature), 32'(sig));
`endif
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        num_vec = '0;
        op      = '0;
        valid   = 1'b0;
        a       = '0;
        b       = '0;
        result  = '0;
        tick();
        tick();
        check_all_zero("reset");
`ifdef RESP_MISR_EN
        check("reset_sig", 32'(signature), 32'h3F);
`endif
        rst = 1'b0;
        tick();

        // Two correct OR vectors.
        do_start(8'd2);
        check("run_ready", 32'(ready), 1);
        check("run_busy",  32'(busy), 1);
        send(6'b001110, 6'b010100, 2'b01, 6'b011110);
        send(6'b111111, 6'b101010, 2'b01, 6'b111111);
        check("two_done", 32'(done), 1);
        check("two_pass", 32'(pass), 1);
        check("two_err",  32'(err_count), 0);

        // One wrong OR response.
        do_start(8'd1);
        send(6'b001110, 6'b010100, 2'b01, 6'b011100);
        check("one_err",  32'(err_count), 1);
        check("one_fidx", 32'(first_err_idx), 0);
        check("one_fexp", 32'(first_err_exp), 32'h1E);
        check("one_pass", 32'(pass), 0);
        check("one_done", 32'(done), 1);

        // Empty run: ready stays low throughout.
        check("zero_pre_ready", 32'(ready), 0);
        do_start(8'd0);
        check("zero_done",  32'(done), 1);
        check("zero_pass",  32'(pass), 1);
        check("zero_ready", 32'(ready), 0);
        check("zero_err",   32'(err_count), 0);
        tick();
        check("zero_ready2", 32'(ready), 0);

        // Gap in valid and an ignored start pulse mid-run.
        do_start(8'd3);
        send(6'b101010, 6'b010101, 2'b10, 6'b111111);
        tick();
        tick();
        check("gap_busy", 32'(busy), 1);
        start   = 1'b1;
        num_vec = 8'd1;
        tick();
        start   = 1'b0;
        send(6'b110000, 6'b001100, 2'b11, 6'b000011);
        check("restart_busy", 32'(busy), 1);
        send(6'b000000, 6'b000000, 2'b00, 6'b000001);
        check("gap_done", 32'(done), 1);
        check("gap_err",  32'(err_count), 1);
        check("gap_fidx", 32'(first_err_idx), 2);
        check("gap_fexp", 32'(first_err_exp), 0);

        // valid while in DONE is ignored and outputs hold.
        send(6'b000000, 6'b000000, 2'b00, 6'b111111);
        tick();
        check("hold_err",  32'(err_count), 1);
        check("hold_done", 32'(done), 1);
        check("hold_fidx", 32'(first_err_idx), 2);

        // Asynchronous reset mid-run clears everything without a clock edge.
        do_start(8'd3);
        send(6'b111111, 6'b111111, 2'b00, 6'b000000);
        check("pre_rst_err", 32'(err_count), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        tick();
        send(6'b111111, 6'b111111, 2'b00, 6'b000000);
        check("idle_ignore_err",  32'(err_count), 0);
        check("idle_ignore_busy", 32'(busy), 0);

`ifdef RESP_MISR_EN
        do_start(8'd1);
        check("misr_reload", 32'(signature), 32'h3F);
        send(6'b001110, 6'b010100, 2'b01, 6'b011110);
        check("misr_one", 32'(signature), 32'h23);
`endif

        // Largest run, every response wrong: count reaches 255.
        do_start(8'd255);
        for (int i = 0; i < 255; i++) begin
            send(6'b000000, 6'b111111, 2'b01, 6'b000000);
        end
        check("max_done", 32'(done), 1);
        check("max_err",  32'(err_count), 255);
        check("max_fidx", 32'(first_err_idx), 0);
        check("max_fexp", 32'(first_err_exp), 32'h3F);
        check("max_pass", 32'(pass), 0);

        for (int r = 0; r < 8; r++) begin
            random_run(int'($urandom_range(1, 12)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_bitwise_resp_checker
`default_nettype wire

// File: doc/bitwise_resp_checker.md
BITWISE_RESP_CHECKER -- requirements
Module: bitwise_resp_checker

Interface
REQ-001 SHALL have parameter N, default 6, giving the operand/result width in bits.
REQ-002 SHALL have parameter POLY, default 6'b000011 (x^6+x+1), giving the MISR feedback taps, N bits wide.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: a one-cycle pulse that begins a check run.
REQ-007 Port num_vec, input, 8 bits: the number of vectors in the run, sampled on start.
REQ-008 Port op, input, 2 bits: the operation for the current vector (00 AND, 01 OR, 10 XOR, 11 NOR).
REQ-009 Port valid, input, 1 bit: a, b, result and op carry a vector.
REQ-010 Ports a and b, inputs, N bits each: the operands applied to the block under check.
REQ-011 Port result, input, N bits: the output of the block under check.
REQ-012 Port ready, output, 1 bit: the checker accepts a vector.
REQ-013 Ports busy and done, outputs, 1 bit each: busy is high in RUN, done is high in DONE.
REQ-014 Port pass, output, 1 bit: the run finished with zero mismatches.
REQ-015 Port err_count, output, 8 bits: the mismatch count.
REQ-016 Ports first_err_idx (8 bits) and first_err_exp (N bits), outputs: the vector index and expected value of the first mismatch.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE.
- IDLE -> RUN on start with num_vec>0.
- IDLE -> DONE on start with num_vec=0.
- DONE -> RUN or DONE on start, with the same num_vec rule.
REQ-018 On start, err_count, the vector counter, first_err_* and pass SHALL clear; no vector is accepted in the start cycle.
REQ-019 ready SHALL equal 1 only in RUN; a vector is accepted when valid and ready are both 1.
REQ-020 The expected value SHALL be op applied bitwise to a and b, using the op present with that vector.
REQ-021 Each accepted vector SHALL increment the vector counter one cycle after acceptance; a mismatch SHALL increment err_count in the same cycle, saturating at 255.
REQ-022 On the first mismatch only, first_err_idx SHALL capture the vector index (0-based) and first_err_exp the expected value.
REQ-023 After the num_vec-th vector is accepted, the FSM SHALL enter DONE on the next edge; all counters are final in that cycle.
REQ-024 In DONE, pass SHALL equal (err_count==0), and all outputs SHALL hold until the next start.
REQ-025 start in RUN SHALL be ignored, and valid outside RUN SHALL be ignored.
REQ-026 Gaps in valid SHALL not advance any state.

Reset
REQ-027 rst SHALL force IDLE and clear ready, busy, done, pass, err_count, first_err_idx and first_err_exp to 0 immediately, including in mid-run.
REQ-028 Under RESP_MISR_EN, rst SHALL also set signature to all-ones.

Configuration
REQ-029 Macro RESP_MISR_EN defined:
- Output port signature, N bits, is present.
- start reloads signature to all-ones.
- Each accepted vector updates signature to {sig[N-2:0],0} ^ (sig[N-1] ? POLY : 0) ^ result.
REQ-030 Macro RESP_MISR_EN undefined: the signature port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package bitwise_chk_pkg SHALL hold:
- The op_e enum (AND, OR, XOR, NOR).
- The state_e enum (IDLE, RUN, DONE).
- The localparam CNT_W=8.
REQ-032 Combinational sub-module bitwise_ref_model(a, b, op -> expected) SHALL compute the expected value, and its N SHALL be inherited from bitwise_resp_checker.

Verification (N=6)
REQ-033 start with num_vec=2, op=OR, vectors (001110,010100,011110) and (111111,101010,111111) -> done=1, pass=1, err_count=0.
REQ-034 num_vec=1, op=OR, a=001110, b=010100, result=011100 -> err_count=1, first_err_idx=0, first_err_exp=011110, pass=0.
REQ-035 start with num_vec=0 -> done=1 and pass=1 on the next cycle, with ready never asserted.
REQ-036 num_vec=3 with a two-cycle valid gap and a start pulse during RUN -> exactly 3 vectors counted and the run is not restarted.
REQ-037 rst asserted after 1 of 3 vectors -> all outputs are 0 in the same cycle, and the FSM is in IDLE.
REQ-038 RESP_MISR_EN defined, one vector with result=011110 after start -> signature=100011.
